// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM encoding and stream framing constants for the instruction-memory loader
package loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;
  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/word_assembler_32.sv
// word_assembler_32: packs four big-endian stream bytes into one 32-bit word
module word_assembler_32
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic [31:0] word_out,
  output logic        word_done
);
  logic [23:0] sr;
  logic [1:0]  cnt;
  // The 4th byte completes the word combinationally so the top can register it on the same edge
  assign word_out  = {sr, byte_in};
  assign word_done = byte_en && cnt == 2'(WORD_BYTES - 1);
  // Shift earlier bytes toward the MSB and count bytes within the current word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (byte_en) begin
      sr  <= {sr[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed big-endian byte stream into instruction memory, then releases the core
module imem_loader
  import loader_pkg::*;
#(
  parameter int          depth_words  = 256,
  parameter logic [31:0] base_address = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_write_enabled,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data,
  output logic             cpu_run,
  output logic             busy,
  output logic             err_length,
  output logic [CNT_W-1:0] words_loaded
);
  state_t      state;
  logic [15:0] len;
  logic [15:0] len_n;
  logic [31:0] word;
  logic        word_done;
  logic        accept;
  logic        restart;
  assign accept  = in_valid && in_ready;
  assign restart = start && !busy;
  assign len_n   = {len[15:8], in_data};
  word_assembler_32 u_asm (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (restart),
    .byte_in  (in_data),
    .byte_en  (accept && state == S_DATA),
    .word_out (word),
    .word_done(word_done)
  );
  // Loader FSM with registered handshake, status and memory-write outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      len               <= '0;
      in_ready          <= 1'b0;
      mem_write_enabled <= 1'b0;
      mem_address       <= '0;
      mem_data          <= '0;
      cpu_run           <= 1'b0;
      busy              <= 1'b0;
      err_length        <= 1'b0;
      words_loaded      <= '0;
    end else begin
      mem_write_enabled <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          cpu_run <= state == S_DONE && !start;
          if (start) begin
            state        <= S_LEN_HI;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            err_length   <= 1'b0;
            words_loaded <= '0;
          end
        end
        S_LEN_HI: if (accept) begin
          len[15:8] <= in_data;
          state     <= S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          len <= len_n;
          if (len_n == 16'd0 || 32'(len_n) > 32'(depth_words)) begin
            state      <= len_n == 16'd0 ? S_DONE : S_ERROR;
            err_length <= len_n != 16'd0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (word_done) begin
          mem_write_enabled <= 1'b1;
          mem_data          <= word;
          mem_address       <= base_address + (32'(words_loaded) << 2);
          words_loaded      <= words_loaded + 16'd1;
          if (words_loaded + 16'd1 == len) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
